// File: rtl/bus_arbiter_pkg.sv
// bus_pkg: shared state encoding, master indices and bus width for the arbiter
package bus_pkg;
  localparam int BUS_W = 32;
  localparam int M0 = 0;
  localparam int M1 = 1;
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: two requesting masters plus the shared slave bus
interface bus_arbiter_if;
  import bus_pkg::*;
  logic m0_req, m0_we, m0_ack;
  logic m1_req, m1_we, m1_ack;
  logic [BUS_W-1:0] m0_addr, m0_wdata, m0_rdata;
  logic [BUS_W-1:0] m1_addr, m1_wdata, m1_rdata;
  logic [BUS_W-1:0] address, dataOut, dataIn;
  logic busWriteEnable;
  logic [1:0] grant;
  modport slave (
    input m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, dataIn,
    output m0_rdata, m0_ack, m1_rdata, m1_ack, address, dataOut, busWriteEnable, grant
  );
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, dataIn,
    input m0_rdata, m0_ack, m1_rdata, m1_ack, address, dataOut, busWriteEnable, grant
  );
endinterface

// File: rtl/bus_arbiter_rr_pick2.sv
// rr_pick2: two-requester round-robin selector; on contention the master not granted last wins
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);
  assign pick = &req ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter onto a single-slave bus with fixed wait states
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input logic        clk,
  input logic        reset,
  bus_arbiter_if.slave bus
);
  state_t state, nxt;
  logic [3:0] cnt;
  logic owner, last, we;
  logic [BUS_W-1:0] addr, wdata;
  logic [BUS_W-1:0] rdata [2];
  logic [1:0] pick;
  rr_pick2 u_pick (
    .req ({bus.m1_req, bus.m0_req}),
    .last(last),
    .pick(pick)
  );
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (|pick ? ACCESS : IDLE) :
          state == ACCESS ? (cnt == 4'd0 ? ACK : ACCESS) : IDLE;
  // Everything the transaction needs is captured at grant so requesters may drop or change req afterwards
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      owner <= 1'b0;
      last <= 1'b1;
      we <= 1'b0;
      addr <= '0;
      wdata <= '0;
      rdata[M0] <= '0;
      rdata[M1] <= '0;
    end else begin
      if (state == IDLE && |pick) begin
        owner <= pick[1];
        last <= pick[1];
        we <= pick[1] ? bus.m1_we : bus.m0_we;
        addr <= pick[1] ? bus.m1_addr : bus.m0_addr;
        wdata <= pick[1] ? bus.m1_wdata : bus.m0_wdata;
        cnt <= 4'(WAIT_STATES);
      end
      if (state == ACCESS && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (state == ACCESS && cnt == 4'd0 && !we) rdata[owner] <= bus.dataIn;
    end
  always_comb begin
    bus.address = state == ACCESS ? addr : '0;
    bus.dataOut = state == ACCESS ? wdata : '0;
    bus.busWriteEnable = state == ACCESS && we;
    bus.grant = state == IDLE ? 2'b00 : (owner ? 2'b10 : 2'b01);
    bus.m0_ack = state == ACK && !owner;
    bus.m1_ack = state == ACK && owner;
    bus.m0_rdata = rdata[M0];
    bus.m1_rdata = rdata[M1];
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_bus_arbiter;
  import bus_pkg::*;
  localparam int WS = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  bus_arbiter_if ia ();
  bus_arbiter_if ib ();
  bus_arbiter #(.WAIT_STATES(0)) dut_a (.clk(clk), .reset(rst), .bus(ia));
  bus_arbiter #(.WAIT_STATES(WS)) dut_b (.clk(clk), .reset(rst), .bus(ib));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    {ia.m0_req, ia.m0_we, ia.m1_req, ia.m1_we} = '0;
    {ia.m0_addr, ia.m0_wdata, ia.m1_addr, ia.m1_wdata, ia.dataIn} = '0;
    {ib.m0_req, ib.m0_we, ib.m1_req, ib.m1_we} = '0;
    {ib.m0_addr, ib.m0_wdata, ib.m1_addr, ib.m1_wdata, ib.dataIn} = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    checks++;
    if ({ib.grant, ib.m0_ack, ib.m1_ack, ib.busWriteEnable} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got grant=%b acks=%b%b bwe=%b want 0", ib.grant, ib.m0_ack, ib.m1_ack, ib.busWriteEnable);
    end
    checks++;
    if ({ib.address, ib.dataOut} !== 64'h0) begin
      errors++;
      $display("FAIL reset_bus got addr=%h dout=%h want 0", ib.address, ib.dataOut);
    end
    checks++;
    if ({ib.m0_rdata, ib.m1_rdata, ia.m0_rdata, ia.m1_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h %h want 0", ib.m0_rdata, ib.m1_rdata);
    end
    checks++;
    if ({ia.grant, ia.busWriteEnable, ia.address} !== 35'h0) begin
      errors++;
      $display("FAIL reset_ws0 got grant=%b bwe=%b addr=%h want 0", ia.grant, ia.busWriteEnable, ia.address);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_ws0;
    ia.m0_req = 1'b1;
    ia.m0_we = 1'b0;
    ia.m0_addr = 32'h100;
    ia.dataIn = 32'hDEADBEEF;
    tick();
    checks++;
    if ({ia.grant, ia.busWriteEnable, ia.m0_ack, ia.address} !== {2'b01, 1'b0, 1'b0, 32'h100}) begin
      errors++;
      $display("FAIL ws0_access got grant=%b bwe=%b ack=%b addr=%h want 01 0 0 00000100", ia.grant, ia.busWriteEnable, ia.m0_ack, ia.address);
    end
    tick();
    ia.m0_req = 1'b0;
    checks++;
    if ({ia.m0_ack, ia.m1_ack, ia.busWriteEnable, ia.m0_rdata} !== {3'b100, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL ws0_ack got ack=%b%b bwe=%b rdata=%h want 10 0 deadbeef", ia.m0_ack, ia.m1_ack, ia.busWriteEnable, ia.m0_rdata);
    end
    tick();
    checks++;
    if ({ia.m0_ack, ia.grant, ia.address} !== 35'h0) begin
      errors++;
      $display("FAIL ws0_idle got ack=%b grant=%b addr=%h want 0", ia.m0_ack, ia.grant, ia.address);
    end
  endtask

  task automatic test_write_ws2;
    logic [6:0] hi = '0;
    int ack_at = -1;
    int acks = 0;
    ib.m1_req = 1'b1;
    ib.m1_we = 1'b1;
    ib.m1_addr = 32'h200;
    ib.m1_wdata = 32'h12345678;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (ib.busWriteEnable && ib.address == 32'h200 && ib.dataOut == 32'h12345678 && ib.grant == 2'b10) hi[k] = 1'b1;
      if (ib.m1_ack) begin
        acks++;
        ack_at = k;
      end
      if (ib.m0_ack) acks += 10;
      if (k == 4) ib.m1_req = 1'b0;
    end
    checks++;
    if (hi !== 7'b0001110) begin
      errors++;
      $display("FAIL ws2_write_cycles got mask=%b want 0001110", hi);
    end
    checks++;
    if (ack_at != 4 || acks != 1) begin
      errors++;
      $display("FAIL ws2_write_ack got cycle=%0d count=%0d want cycle=4 count=1", ack_at, acks);
    end
    checks++;
    if (ib.m1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL ws2_write_rdata got %h want 00000000", ib.m1_rdata);
    end
  endtask

  task automatic test_contention;
    logic [1:0] seq [4];
    logic [1:0] prev = 2'b00;
    int n = 0;
    rst = 1'b1;
    ib.m0_req = 1'b1;
    ib.m1_req = 1'b1;
    ib.m0_we = 1'b0;
    ib.m1_we = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      tick();
      if (prev == 2'b00 && ib.grant != 2'b00) begin
        seq[n] = ib.grant;
        n++;
      end
      prev = ib.grant;
      if (ib.m0_ack || ib.m1_ack) begin
        checks++;
        if ({ib.m1_ack, ib.m0_ack} !== ib.grant) begin
          errors++;
          $display("FAIL contention_ack got acks=%b%b grant=%b want ack matching owner", ib.m1_ack, ib.m0_ack, ib.grant);
        end
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL contention_timeout got %0d grants want 4", n);
    end else begin
      checks++;
      if ({seq[0], seq[1], seq[2], seq[3]} !== 8'b01100110) begin
        errors++;
        $display("FAIL contention_order got %b %b %b %b want 01 10 01 10", seq[0], seq[1], seq[2], seq[3]);
      end
    end
    ib.m0_req = 1'b0;
    ib.m1_req = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_reset_abort;
    int ack_at = -1;
    int bad = 0;
    ib.m0_req = 1'b1;
    ib.m0_we = 1'b1;
    ib.m0_addr = 32'h300;
    ib.m0_wdata = 32'hAA;
    repeat (2) tick();
    checks++;
    if (ib.busWriteEnable !== 1'b1) begin
      errors++;
      $display("FAIL abort_access got bwe=%b want 1", ib.busWriteEnable);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({ib.busWriteEnable, ib.grant, ib.m0_ack, ib.m1_ack} !== 5'b0) begin
      errors++;
      $display("FAIL abort_state got bwe=%b grant=%b acks=%b%b want 0", ib.busWriteEnable, ib.grant, ib.m0_ack, ib.m1_ack);
    end
    rst = 1'b0;
    ib.m0_req = 1'b0;
    ib.m1_req = 1'b1;
    ib.m1_we = 1'b0;
    ib.m1_addr = 32'h400;
    ib.dataIn = 32'h5555AAAA;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (ib.m0_ack) bad++;
      if (ib.m1_ack) begin
        ack_at = k;
        ib.m1_req = 1'b0;
      end
      if (k == 1 && ib.grant != 2'b10) bad++;
    end
    checks++;
    if (ack_at != 4 || bad != 0) begin
      errors++;
      $display("FAIL abort_next got ack_cycle=%0d bad=%0d want 4 0", ack_at, bad);
    end
    checks++;
    if (ib.m1_rdata !== 32'h5555AAAA) begin
      errors++;
      $display("FAIL abort_rdata got %h want 5555aaaa", ib.m1_rdata);
    end
  endtask

  task automatic test_drop;
    int acks = 0;
    ib.m0_req = 1'b1;
    ib.m0_we = 1'b0;
    ib.m0_addr = 32'h500;
    ib.dataIn = 32'hCAFEF00D;
    tick();
    ib.m0_req = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      tick();
      if (ib.m0_ack) acks++;
    end
    checks++;
    if (acks != 1) begin
      errors++;
      $display("FAIL drop_ack got %0d pulses want 1", acks);
    end
    checks++;
    if (ib.m0_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL drop_rdata got %h want cafef00d", ib.m0_rdata);
    end
    acks = 0;
    ib.m0_req = 1'b1;
    ib.m0_we = 1'b1;
    ib.m0_wdata = 32'h77;
    ib.dataIn = 32'h11111111;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (ib.m0_ack) begin
        acks++;
        ib.m0_req = 1'b0;
      end
    end
    checks++;
    if (acks != 1 || ib.m0_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL write_keeps_rdata got acks=%0d rdata=%h want 1 cafef00d", acks, ib.m0_rdata);
    end
  endtask

  task automatic test_random;
    bit rq [2] = '{0, 0};
    bit rwe [2];
    logic [31:0] ra [2];
    logic [31:0] rw [2];
    logic [31:0] exp_rd [2] = '{32'h0, 32'h0};
    bit busy = 0;
    bit mwe = 0;
    int t0 = 0;
    int own = 0;
    int last_m = 1;
    logic [31:0] maddr = '0;
    logic [31:0] mwdata = '0;
    rst = 1'b1;
    idle_inputs();
    repeat (2) tick();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int ph = c - t0;
      bit acc = busy && ph >= 1 && ph <= 1 + WS;
      bit ackc = busy && ph == 2 + WS;
      logic [1:0] eg = (acc || ackc) ? (own == 1 ? 2'b10 : 2'b01) : 2'b00;
      checks++;
      if (ib.grant !== eg) begin
        errors++;
        $display("FAIL rnd_grant cycle %0d got %b want %b", c, ib.grant, eg);
      end
      checks++;
      if ({ib.busWriteEnable, ib.address, ib.dataOut} !== {acc && mwe, acc ? maddr : 32'h0, acc ? mwdata : 32'h0}) begin
        errors++;
        $display("FAIL rnd_bus cycle %0d got bwe=%b addr=%h dout=%h want bwe=%b addr=%h dout=%h", c,
                 ib.busWriteEnable, ib.address, ib.dataOut, acc && mwe, acc ? maddr : 32'h0, acc ? mwdata : 32'h0);
      end
      checks++;
      if ({ib.m1_ack, ib.m0_ack} !== {ackc && own == 1, ackc && own == 0}) begin
        errors++;
        $display("FAIL rnd_ack cycle %0d got %b%b want %b%b", c, ib.m1_ack, ib.m0_ack, ackc && own == 1, ackc && own == 0);
      end
      checks++;
      if ({ib.m0_rdata, ib.m1_rdata} !== {exp_rd[0], exp_rd[1]}) begin
        errors++;
        $display("FAIL rnd_rdata cycle %0d got %h %h want %h %h", c, ib.m0_rdata, ib.m1_rdata, exp_rd[0], exp_rd[1]);
      end
      for (int i = 0; i < 2; i++) begin
        if (ackc && own == i) begin
          rq[i] = 1'($urandom_range(0, 1));
          rwe[i] = 1'($urandom_range(0, 1));
          ra[i] = $urandom;
          rw[i] = $urandom;
        end else if (acc && own == i) begin
          if (rq[i] && $urandom_range(0, 3) == 0) begin
            rq[i] = 1'b0;
            rwe[i] = ~rwe[i];
            ra[i] = $urandom;
            rw[i] = $urandom;
          end
        end else if (!rq[i] && $urandom_range(0, 2) == 0) begin
          rq[i] = 1'b1;
          rwe[i] = 1'($urandom_range(0, 1));
          ra[i] = $urandom;
          rw[i] = $urandom;
        end
      end
      {ib.m0_req, ib.m0_we, ib.m0_addr, ib.m0_wdata} = {rq[0], rwe[0], ra[0], rw[0]};
      {ib.m1_req, ib.m1_we, ib.m1_addr, ib.m1_wdata} = {rq[1], rwe[1], ra[1], rw[1]};
      ib.dataIn = $urandom;
      if (acc && ph == 1 + WS && !mwe) exp_rd[own] = ib.dataIn;
      if (!acc && !ackc && (rq[0] || rq[1])) begin
        own = (rq[0] && rq[1]) ? 1 - last_m : (rq[1] ? 1 : 0);
        last_m = own;
        busy = 1'b1;
        t0 = c;
        mwe = rwe[own];
        maddr = ra[own];
        mwdata = rw[own];
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_read_ws0();
    test_write_ws2();
    test_contention();
    test_reset_abort();
    test_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
